// File: rtl/snn_timestep_sequencer.sv
// Timestep sequencer for the two-layer delayed SNN: frame intake, settle window,
// output sampling, delay-line tick and windowed per-neuron spike counting.
module snn_spike_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clr)
            r_count <= '0;
        else if (i_inc && (r_count != {CNT_W{1'b1}}))
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;
endmodule

module snn_timestep_sequencer #(
    parameter int M1       = 24,
    parameter int N2       = 2,
    parameter int CNT_W    = 8,
    parameter int SETTLE_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SETTLE_W-1:0] cfg_settle_cycles,
    input  logic [7:0]          cfg_window_len,
    input  logic                frame_valid,
    output logic                frame_ready,
    input  logic [M1-1:0]       frame_spikes,
    output logic [M1-1:0]       net_input_spikes,
    output logic                net_enable,
    output logic                net_delay_clk,
    input  logic [N2-1:0]       net_output_spikes,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [N2*CNT_W-1:0] result_counts,
    output logic                busy
);
    typedef enum logic [1:0] {WAIT_FRAME, RUN, TICK, EMIT} state_t;

    state_t                      r_state, w_next;
    logic [M1-1:0]               r_in_spikes;
    logic [SETTLE_W-1:0]         r_settle, r_s_lat;
    logic [7:0]                  r_step, r_win;
    logic [N2-1:0][CNT_W-1:0]    w_counts;
    logic                        w_accept, w_last_run, w_clr_counts;
    logic [7:0]                  w_step_nxt;

    assign w_accept     = frame_valid && (r_state == WAIT_FRAME);
    assign w_last_run   = (r_state == RUN) && (r_settle == r_s_lat);
    assign w_clr_counts = reset || ((r_state == EMIT) && result_ready);
    assign w_step_nxt   = r_step + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) r_state <= WAIT_FRAME;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_FRAME: if (w_accept) w_next = RUN;
            RUN:        if (r_settle == r_s_lat) w_next = TICK;
            TICK:       w_next = (w_step_nxt == r_win) ? EMIT : WAIT_FRAME;
            EMIT:       if (result_ready) w_next = WAIT_FRAME;
            default:    w_next = WAIT_FRAME;
        endcase
    end

    // Window length is captured only on the first frame so mid-window edits are inert.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_spikes <= '0;
            r_settle    <= '0;
            r_s_lat     <= '0;
            r_step      <= '0;
            r_win       <= 8'd1;
        end else begin
            case (r_state)
                WAIT_FRAME: if (w_accept) begin
                    r_in_spikes <= frame_spikes;
                    r_s_lat     <= cfg_settle_cycles;
                    r_settle    <= '0;
                    if (r_step == 8'd0)
                        r_win <= (cfg_window_len == 8'd0) ? 8'd1 : cfg_window_len;
                end
                RUN:  r_settle <= r_settle + 1'b1;
                TICK: begin
                    r_in_spikes <= '0;
                    r_step      <= w_step_nxt;
                end
                EMIT: if (result_ready) r_step <= '0;
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < N2; gi++) begin : g_cnt
        snn_spike_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .i_clr   (w_clr_counts),
            .i_inc   (w_last_run && net_output_spikes[gi]),
            .o_count (w_counts[gi])
        );
    end

    assign frame_ready      = (r_state == WAIT_FRAME);
    assign busy             = (r_state != WAIT_FRAME);
    assign net_enable       = (r_state == RUN);
    assign net_delay_clk    = (r_state == TICK);
    assign result_valid     = (r_state == EMIT);
    assign result_counts    = (r_state == EMIT) ? w_counts : '0;
    assign net_input_spikes = r_in_spikes;
endmodule

// File: tb/tb_snn_timestep_sequencer.sv
// Scoreboard bench: two sequencer instances (8-bit and 2-bit counters), directed windows.
module tb_snn_timestep_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cfg_settle_cycles = '0;
    logic [7:0]  cfg_window_len = '0;
    logic        frame_valid = 1'b0;
    logic [23:0] frame_spikes = '0;
    logic [1:0]  net_output_spikes = '0;
    logic        result_ready = 1'b0;
    bit          sel = 1'b0;

    logic        a_fr, a_en, a_dclk, a_rv, a_busy;
    logic [23:0] a_in;
    logic [15:0] a_rc;
    logic        b_fr, b_en, b_dclk, b_rv, b_busy;
    logic [23:0] b_in;
    logic [3:0]  b_rc;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    always #5 clk = ~clk;

    snn_timestep_sequencer #(.M1(24), .N2(2), .CNT_W(8), .SETTLE_W(4)) u_a (
        .clk(clk), .reset(reset), .cfg_settle_cycles(cfg_settle_cycles),
        .cfg_window_len(cfg_window_len), .frame_valid(frame_valid && !sel),
        .frame_ready(a_fr), .frame_spikes(frame_spikes), .net_input_spikes(a_in),
        .net_enable(a_en), .net_delay_clk(a_dclk), .net_output_spikes(net_output_spikes),
        .result_valid(a_rv), .result_ready(result_ready), .result_counts(a_rc), .busy(a_busy));

    snn_timestep_sequencer #(.M1(24), .N2(2), .CNT_W(2), .SETTLE_W(4)) u_b (
        .clk(clk), .reset(reset), .cfg_settle_cycles(cfg_settle_cycles),
        .cfg_window_len(cfg_window_len), .frame_valid(frame_valid && sel),
        .frame_ready(b_fr), .frame_spikes(frame_spikes), .net_input_spikes(b_in),
        .net_enable(b_en), .net_delay_clk(b_dclk), .net_output_spikes(net_output_spikes),
        .result_valid(b_rv), .result_ready(result_ready), .result_counts(b_rc), .busy(b_busy));

    wire        w_fr   = sel ? b_fr   : a_fr;
    wire        w_en   = sel ? b_en   : a_en;
    wire        w_dclk = sel ? b_dclk : a_dclk;
    wire        w_rv   = sel ? b_rv   : a_rv;
    wire        w_busy = sel ? b_busy : a_busy;
    wire [23:0] w_in   = sel ? b_in   : a_in;
    wire [31:0] w_rc   = sel ? {28'd0, b_rc} : {16'd0, a_rc};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result monitor: pops the scoreboard on every accepted result.
    always @(negedge clk) begin
        if (a_rv && result_ready) begin
            if (qa.size() == 0) chk("unexpected_result_a", 32'd1, 32'd0);
            else chk("result_a", {16'd0, a_rc}, qa.pop_front());
        end
        if (b_rv && result_ready) begin
            if (qb.size() == 0) chk("unexpected_result_b", 32'd1, 32'd0);
            else chk("result_b", {28'd0, b_rc}, qb.pop_front());
        end
    end

    // Starts and ends on a negedge; ends one cycle after the TICK cycle.
    task automatic do_step(input logic [23:0] f, input logic [1:0] sp, input int s_exp);
        int n = 0;
        int en_cnt = 0;
        int tick_cnt = 0;
        while (!w_fr && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("frame_ready_timeout", 32'd0, 32'd1);
        frame_spikes = f;
        net_output_spikes = sp;
        frame_valid = 1'b1;
        @(posedge clk); #1 frame_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("run_input_spikes", {8'd0, w_in}, {8'd0, f});
                chk("run_busy", {31'd0, w_busy}, 32'd1);
            end
            if (w_en) en_cnt++;
            if (w_dclk) begin tick_cnt++; break; end
        end
        chk("enable_cycles", en_cnt, s_exp + 1);
        chk("delay_pulse", tick_cnt, 32'd1);
        @(negedge clk);
        chk("spikes_cleared", {8'd0, w_in}, 32'd0);
    endtask

    task automatic drain(input int hold, input logic [31:0] expv);
        int n = 0;
        while (!w_rv && n < 30) begin @(negedge clk); n++; end
        if (n >= 30) chk("result_valid_timeout", 32'd0, 32'd1);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", {31'd0, w_rv}, 32'd1);
            chk("hold_counts", w_rc, expv);
            chk("hold_frame_ready", {31'd0, w_fr}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1 result_ready = 1'b1;
        @(posedge clk); #1 result_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", {31'd0, w_rv}, 32'd0);
        chk("post_frame_ready", {31'd0, w_fr}, 32'd1);
        chk("post_counts", w_rc, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_frame_ready", {31'd0, a_fr}, 32'd1);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_enable", {31'd0, a_en}, 32'd0);
        chk("rst_delay_clk", {31'd0, a_dclk}, 32'd0);
        chk("rst_result_valid", {31'd0, a_rv}, 32'd0);
        chk("rst_counts", {16'd0, a_rc}, 32'd0);
        chk("rst_input_spikes", {8'd0, a_in}, 32'd0);
        chk("rst_b_frame_ready", {31'd0, b_fr}, 32'd1);

        // S=2, W=3, neuron 0 fires each step; window edit mid-window is ignored
        sel = 1'b0; cfg_settle_cycles = 4'd2; cfg_window_len = 8'd3;
        qa.push_back(32'h0003);
        do_step(24'hA5A5A5, 2'b01, 2);
        cfg_window_len = 8'd7;
        do_step(24'hA5A5A5, 2'b01, 2);
        do_step(24'hA5A5A5, 2'b01, 2);
        drain(5, 32'h0003);

        // W=0 treated as one timestep, S=0
        cfg_settle_cycles = 4'd0; cfg_window_len = 8'd0;
        qa.push_back(32'h0100);
        do_step(24'h000001, 2'b10, 0);
        drain(1, 32'h0100);

        // 2-bit counters saturate at 3 over five steps
        sel = 1'b1; cfg_settle_cycles = 4'd1; cfg_window_len = 8'd5;
        qb.push_back(32'hF);
        for (int i = 0; i < 5; i++) do_step(24'h800000 >> i, 2'b11, 1);
        drain(0, 32'hF);

        // Reset in second RUN cycle of step 2 abandons the window
        sel = 1'b0; cfg_settle_cycles = 4'd2; cfg_window_len = 8'd3;
        do_step(24'h123456, 2'b11, 2);
        @(negedge clk);
        frame_spikes = 24'h654321; frame_valid = 1'b1;
        @(posedge clk); #1 frame_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_frame_ready", {31'd0, a_fr}, 32'd1);
        chk("mid_rst_busy", {31'd0, a_busy}, 32'd0);
        chk("mid_rst_input_spikes", {8'd0, a_in}, 32'd0);
        chk("mid_rst_enable", {31'd0, a_en}, 32'd0);
        chk("mid_rst_result_valid", {31'd0, a_rv}, 32'd0);
        cfg_settle_cycles = 4'd0; cfg_window_len = 8'd1;
        qa.push_back(32'h0001);
        do_step(24'h0F0F0F, 2'b01, 0);
        drain(1, 32'h0001);

        repeat (3) @(negedge clk);
        chk("scoreboard_a_empty", qa.size(), 32'd0);
        chk("scoreboard_b_empty", qb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
